// File: rtl/fifo_bist_driver.sv
// Traffic driver and checker for the synchronous FIFO: writes a SEED+k ramp in
// fill/drain bursts, tracks occupancy, checks read data, ack and status flags.
//
// state | meaning
// IDLE  | waiting for start, nothing driven
// FILL  | writing words until the FIFO is full or all words are issued
// DRAIN | reading until the occupancy model reaches zero
// FLUSH | last read data is compared this cycle
// DONE  | run complete, counts held, start reruns

module fifo_bist_driver #(
    parameter int FIFO_WIDTH = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int NUM_TXN    = 20,
    parameter logic [FIFO_WIDTH-1:0] SEED = 'h0100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [FIFO_WIDTH-1:0] data_in,
    output logic                  wr_en,
    output logic                  rd_en,
    input  logic [FIFO_WIDTH-1:0] data_out,
    input  logic                  wr_ack,
    input  logic                  full,
    input  logic                  empty,
    input  logic                  almostfull,
    input  logic                  almostempty,
    input  logic                  overflow,
    input  logic                  underflow,
    output logic                  busy,
    output logic                  done,
    output logic [15:0]           correct_count,
    output logic [15:0]           error_count,
    output logic                  protocol_err
);

    localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [OCC_W-1:0] DEPTH_O = OCC_W'(FIFO_DEPTH);
    localparam logic [15:0] N_TXN = 16'(NUM_TXN);

    typedef enum logic [2:0] {IDLE, FILL, DRAIN, FLUSH, DONE} state_t;

    state_t                  state, state_d;
    logic [OCC_W-1:0]        occ, occ_next;
    logic [15:0]             wr_idx, wr_idx_d;
    logic [15:0]             rd_idx;
    logic                    wr_en_d, rd_en_d;
    logic [FIFO_WIDTH-1:0]   data_in_d;
    logic                    wr_en_q;
    logic                    rd_pend;
    logic                    run_clear;
    logic                    violation;
    logic [FIFO_WIDTH-1:0]   exp_word;

    // occ_next already accounts for the request in flight on this edge, so
    // decisions below never overshoot the FIFO by one word.
    always_comb begin
        occ_next = occ + OCC_W'(wr_en) - OCC_W'(rd_en);
    end

    always_comb begin
        state_d   = state;
        wr_en_d   = 1'b0;
        rd_en_d   = 1'b0;
        data_in_d = data_in;
        wr_idx_d  = wr_idx;
        run_clear = 1'b0;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    run_clear = 1'b1;
                    wr_idx_d  = '0;
                    state_d   = FILL;
                end
            end
            FILL: begin
                if (occ_next == DEPTH_O || wr_idx == N_TXN) begin
                    state_d = DRAIN;
                end else begin
                    wr_en_d   = 1'b1;
                    data_in_d = SEED + FIFO_WIDTH'(wr_idx);
                    wr_idx_d  = wr_idx + 16'd1;
                end
            end
            DRAIN: begin
                if (occ_next == '0) begin
                    state_d = (wr_idx < N_TXN) ? FILL : FLUSH;
                end else begin
                    rd_en_d = 1'b1;
                end
            end
            FLUSH: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        exp_word  = SEED + FIFO_WIDTH'(rd_idx);
        violation = (wr_ack != wr_en_q)
                 || (full != (occ == DEPTH_O))
                 || (empty != (occ == '0))
                 || (almostfull != (occ == DEPTH_O - OCC_W'(1)))
                 || (almostempty != (occ == OCC_W'(1)))
                 || overflow
                 || underflow;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            data_in       <= '0;
            wr_en         <= 1'b0;
            rd_en         <= 1'b0;
            occ           <= '0;
            wr_idx        <= '0;
            rd_idx        <= '0;
            wr_en_q       <= 1'b0;
            rd_pend       <= 1'b0;
            correct_count <= '0;
            error_count   <= '0;
            protocol_err  <= 1'b0;
        end else begin
            state   <= state_d;
            data_in <= data_in_d;
            wr_en   <= wr_en_d;
            rd_en   <= rd_en_d;
            wr_idx  <= wr_idx_d;
            occ     <= occ_next;
            wr_en_q <= wr_en;
            rd_pend <= rd_en;
            if (run_clear) begin
                rd_idx        <= '0;
                correct_count <= '0;
                error_count   <= '0;
                protocol_err  <= 1'b0;
            end else begin
                if (rd_pend) begin
                    rd_idx <= rd_idx + 16'd1;
                    if (data_out == exp_word) begin
                        if (correct_count != 16'hFFFF) correct_count <= correct_count + 16'd1;
                    end else begin
                        if (error_count != 16'hFFFF) error_count <= error_count + 16'd1;
                    end
                end
                if (state != IDLE && violation) protocol_err <= 1'b1;
            end
        end
    end

    always_comb begin
        busy = (state == FILL) || (state == DRAIN) || (state == FLUSH);
        done = (state == DONE);
    end

endmodule

// File: tb/tb_fifo_bist_driver.sv
// Bench for fifo_bist_driver: a behavioural FIFO with fault knobs answers the
// driver, and directed runs compare final counts and flags against constants.

module tb_fifo_bist_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] data_in;
    logic        wr_en, rd_en;
    logic [15:0] data_out;
    logic        wr_ack;
    logic        full, empty, almostfull, almostempty;
    logic        overflow, underflow;
    logic        busy, done;
    logic [15:0] correct_count, error_count;
    logic        protocol_err;

    int n_cmp = 0;
    int n_bad = 0;

    // fault knobs for the FIFO model
    int corrupt_k = -1;
    int noack_k   = -1;
    bit bad_full  = 1'b0;

    always #5 clk = ~clk;

    fifo_bist_driver #(
        .FIFO_WIDTH(16), .FIFO_DEPTH(8), .NUM_TXN(20), .SEED(16'h0100)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .data_in(data_in), .wr_en(wr_en), .rd_en(rd_en),
        .data_out(data_out), .wr_ack(wr_ack),
        .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
        .overflow(overflow), .underflow(underflow),
        .busy(busy), .done(done),
        .correct_count(correct_count), .error_count(error_count),
        .protocol_err(protocol_err)
    );

    logic [15:0] mem [8];
    logic [2:0]  wp, rp;
    logic [3:0]  cnt;
    int          wr_n;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0; rp <= '0; cnt <= '0; wr_n <= 0;
            wr_ack <= 1'b0; data_out <= '0; overflow <= 1'b0; underflow <= 1'b0;
        end else begin
            if (wr_en && cnt != 4'd8) begin
                mem[wp] <= (wr_n == corrupt_k) ? 16'hDEAD : data_in;
                wp <= wp + 3'd1;
                wr_n <= wr_n + 1;
            end
            wr_ack <= wr_en && cnt != 4'd8 && wr_n != noack_k;
            if (rd_en && cnt != 4'd0) begin
                data_out <= mem[rp];
                rp <= rp + 3'd1;
            end
            overflow  <= wr_en && cnt == 4'd8;
            underflow <= rd_en && cnt == 4'd0;
            cnt <= cnt + 4'((wr_en && cnt != 4'd8) ? 1 : 0) - 4'((rd_en && cnt != 4'd0) ? 1 : 0);
        end
    end

    always_comb begin
        full        = (cnt == 4'd8) || (bad_full && cnt == 4'd7);
        empty       = (cnt == 4'd0);
        almostfull  = (cnt == 4'd7);
        almostempty = (cnt == 4'd1);
    end

    int wr_cnt = 0, rd_cnt = 0, both_cnt = 0, busy_cnt = 0;
    always @(negedge clk) begin
        if (wr_en) wr_cnt++;
        if (rd_en) rd_cnt++;
        if (wr_en && rd_en) both_cnt++;
        if (busy) busy_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk) rst_n = 1'b0;
        @(negedge clk) rst_n = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk) #1 start = 1'b1;
        @(posedge clk) #1 start = 1'b0;
    endtask

    task automatic run_to_done(input string tag);
        bit seen = 1'b0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check({tag, "_timeout"}, 32'd0, 32'd1);
    endtask

    initial begin
        int k, b_wr, b_rd, b_both, b_busy;
        bit seen;

        // 1: reset state and golden run
        apply_reset();
        #1;
        check("rst_wr_en", wr_en, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_correct", correct_count, 0);
        check("rst_error", error_count, 0);
        check("rst_perr", protocol_err, 0);
        check("rst_data_in", data_in, 0);

        b_wr = wr_cnt; b_rd = rd_cnt; b_both = both_cnt; b_busy = busy_cnt;
        pulse_start();
        k = 0;
        for (int c = 0; c < 200 && k < 8; c++) begin
            @(negedge clk);
            if (wr_en) begin
                check($sformatf("t1_wdata%0d", k), data_in, 32'h0100 + k);
                k++;
            end
        end
        if (k < 8) check("t1_wdata_timeout", k, 8);
        run_to_done("t1");
        check("t1_done", done, 1);
        check("t1_busy", busy, 0);
        check("t1_correct", correct_count, 20);
        check("t1_error", error_count, 0);
        check("t1_perr", protocol_err, 0);
        check("t1_writes", wr_cnt - b_wr, 20);
        check("t1_reads", rd_cnt - b_rd, 20);
        check("t1_overlap", both_cnt - b_both, 0);
        check("t1_busy_cycles", busy_cnt - b_busy, 47);

        // 2: corrupted sixth word
        apply_reset();
        corrupt_k = 5;
        pulse_start();
        run_to_done("t2");
        check("t2_done", done, 1);
        check("t2_correct", correct_count, 19);
        check("t2_error", error_count, 1);
        check("t2_perr", protocol_err, 0);
        corrupt_k = -1;

        // 3: full flag raised one word early
        apply_reset();
        bad_full = 1'b1;
        pulse_start();
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (rd_en) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("t3_first_read_timeout", 0, 1);
        check("t3_perr_first_fill", protocol_err, 1);
        run_to_done("t3");
        check("t3_correct", correct_count, 20);
        check("t3_perr_end", protocol_err, 1);
        bad_full = 1'b0;

        // 4: missing write acknowledge
        apply_reset();
        noack_k = 2;
        pulse_start();
        run_to_done("t4");
        check("t4_perr", protocol_err, 1);
        check("t4_correct", correct_count, 20);
        check("t4_error", error_count, 0);
        noack_k = -1;

        // 5: reset in the middle of the first fill
        apply_reset();
        b_wr = wr_cnt;
        pulse_start();
        seen = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (wr_cnt - b_wr == 5) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) check("t5_wait_timeout", 0, 1);
        rst_n = 1'b0;
        #1;
        check("t5_wr_en", wr_en, 0);
        check("t5_rd_en", rd_en, 0);
        check("t5_busy", busy, 0);
        check("t5_done", done, 0);
        check("t5_correct_rst", correct_count, 0);
        @(negedge clk) rst_n = 1'b1;
        pulse_start();
        run_to_done("t5");
        check("t5_correct", correct_count, 20);
        check("t5_error", error_count, 0);
        check("t5_perr", protocol_err, 0);

        // 6: start while busy is ignored, start in DONE reruns
        apply_reset();
        b_busy = busy_cnt;
        pulse_start();
        repeat (10) @(negedge clk);
        pulse_start();
        run_to_done("t6a");
        check("t6_busy_cycles", busy_cnt - b_busy, 47);
        check("t6_correct_a", correct_count, 20);
        check("t6_perr_a", protocol_err, 0);
        pulse_start();
        check("t6_done_cleared", done, 0);
        check("t6_busy_rerun", busy, 1);
        run_to_done("t6b");
        check("t6_done_b", done, 1);
        check("t6_correct_b", correct_count, 20);
        check("t6_error_b", error_count, 0);
        check("t6_perr_b", protocol_err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
